ram_march_bist: RTL

- Built-in self-test controller that sits directly upstream of the 1024x8 single-port RAM.
- Drives the RAM's en/address/datain and consumes its dataout.
- On a start pulse it runs a four-phase march (write pattern, read/compare, write inverted pattern, read/compare) over every address.
- Reports pass/fail, the mismatch count and the first failing address to the test-mode controller.

---
 rtl/ram_march_bist.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ram_march_bist.sv
// March BIST for a single-port RAM: WR0 pattern, RD0 compare, WR1 inverted, RD1 compare.
// Outputs registered; read data checked one cycle after its address (1-cycle RAM latency), no backpressure.
module ram_march_bist #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SEED = DATA_WIDTH'(8'h5A)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_datain,
  input  logic [DATA_WIDTH-1:0] ram_dataout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic                  fail_valid,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  fail_phase
);

  localparam int EW = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DONE} state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_n;
  logic                    drain, drain_n;
  logic                    clear;

  logic                    rd_vld_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic                    rd_phase_q;

  logic                    mismatch;
  logic [DATA_WIDTH-1:0]   expect_dat;
  logic                    en_n, busy_n, done_n, pass_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [DATA_WIDTH-1:0]   datain_n;
  logic [EW-1:0]           err_n;
  logic                    fv_n, fphase_n;
  logic [ADDR_WIDTH-1:0]   faddr_n;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
    return DATA_WIDTH'(a) ^ SEED;
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    drain_n = drain;
    clear   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = WR0;
          cnt_n   = '0;
          drain_n = 1'b0;
          clear   = 1'b1;
        end
      end
      WR0, WR1: begin
        if (cnt == LAST) begin
          state_n = (state == WR0) ? RD0 : RD1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      RD0, RD1: begin
        // Extra drain cycle holds the last address while its data returns.
        if (drain) begin
          state_n = (state == RD0) ? WR1 : DONE;
          cnt_n   = '0;
          drain_n = 1'b0;
        end else if (cnt == LAST) begin
          drain_n = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        drain_n = 1'b0;
      end
    endcase
  end

  always_comb begin
    expect_dat = rd_phase_q ? ~pat(rd_addr_q) : pat(rd_addr_q);
    mismatch   = rd_vld_q && (ram_dataout != expect_dat);

    en_n     = (state_n == WR0) || (state_n == WR1);
    busy_n   = state_n inside {WR0, RD0, WR1, RD1};
    done_n   = (state_n == DONE);
    addr_n   = busy_n ? cnt_n : '0;
    datain_n = '0;
    if (state_n == WR0) datain_n = pat(cnt_n);
    if (state_n == WR1) datain_n = ~pat(cnt_n);

    err_n    = clear ? '0 : err_count + EW'(mismatch);
    fv_n     = fail_valid;
    faddr_n  = fail_addr;
    fphase_n = fail_phase;
    if (clear) begin
      fv_n     = 1'b0;
      faddr_n  = '0;
      fphase_n = 1'b0;
    end else if (mismatch && !fail_valid) begin
      fv_n     = 1'b1;
      faddr_n  = rd_addr_q;
      fphase_n = rd_phase_q;
    end
    pass_n = done_n && (err_n == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      drain       <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_phase_q  <= 1'b0;
      ram_en      <= 1'b0;
      ram_address <= '0;
      ram_datain  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      fail_valid  <= 1'b0;
      fail_addr   <= '0;
      fail_phase  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      drain       <= drain_n;
      rd_vld_q    <= ((state == RD0) || (state == RD1)) && !drain;
      rd_addr_q   <= cnt;
      rd_phase_q  <= (state == RD1);
      ram_en      <= en_n;
      ram_address <= addr_n;
      ram_datain  <= datain_n;
      busy        <= busy_n;
      done        <= done_n;
      pass        <= pass_n;
      err_count   <= err_n;
      fail_valid  <= fv_n;
      fail_addr   <= faddr_n;
      fail_phase  <= fphase_n;
    end
  end

endmodule
